// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard bus: the instruction word and source-use flags go in,
// and stall/flush controls plus performance counters come out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr_i;
    logic             hazard_rs1_i;
    logic             hazard_rs2_i;
    logic             branch_taken_i;
    logic             stall_en_o;
    logic             flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Hazard controller side
    modport slave (
        input  instr_i, hazard_rs1_i, hazard_rs2_i, branch_taken_i,
        output stall_en_o, flush_o, stall_cnt_o, flush_cnt_o
    );

    // Pipeline (decode/execute) side
    modport master (
        output instr_i, hazard_rs1_i, hazard_rs2_i, branch_taken_i,
        input  stall_en_o, flush_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: a destination-register
// scoreboard covering EX..WB stalls decode on RAW, and a small FSM
// stretches each taken-branch redirect into a multi-cycle flush.
module hazard_ctrl #(
    parameter int PIPE_DEPTH   = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);
    localparam int FW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [FW-1:0] FRELOAD = FW'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    logic [PIPE_DEPTH-1:0]      sb_vld_q, sb_vld_d;
    logic [PIPE_DEPTH-1:0][4:0] sb_rd_q, sb_rd_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       wr, raw1, raw2, flush_raw, flush, stall;
    logic [PIPE_DEPTH-1:0] hit1, hit2;
    logic       unused_bits;

    assign opcode      = bus.instr_i[6:0];
    assign rd          = bus.instr_i[11:7];
    assign rs1         = bus.instr_i[19:15];
    assign rs2         = bus.instr_i[24:20];
    assign unused_bits = ^{bus.instr_i[31:25], bus.instr_i[14:12]};

    // Producer decode: only opcodes that write rd, and never x0
    always_comb begin
        unique case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0000011, 7'b0010011, 7'b0110011: wr = (rd != 5'd0);
            default:                            wr = 1'b0;
        endcase
    end

    // Per-entry source match; WB is compared too since the regfile write
    // only becomes visible the cycle after retirement
    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_cmp
        assign hit1[k] = sb_vld_q[k] && (sb_rd_q[k] == rs1);
        assign hit2[k] = sb_vld_q[k] && (sb_rd_q[k] == rs2);
    end

    assign raw1 = bus.hazard_rs1_i && (rs1 != 5'd0) && (|hit1);
    assign raw2 = bus.hazard_rs2_i && (rs2 != 5'd0) && (|hit2);

    // Outputs are forced low while reset is held; flush wins over stall
    assign flush = flush_raw & ~rst_i;
    assign stall = (raw1 | raw2) & ~flush & ~rst_i;

    assign bus.flush_o     = flush;
    assign bus.stall_en_o  = stall;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;

    // Flush FSM next state: a redirect in FLUSH reloads, never shortens
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        flush_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                flush_raw = bus.branch_taken_i;
                if (bus.branch_taken_i && (FLUSH_CYCLES > 1)) begin
                    state_d = FLUSH;
                    fcnt_d  = FRELOAD;
                end
            end
            FLUSH: begin
                flush_raw = 1'b1;
                if (bus.branch_taken_i) begin
                    fcnt_d = FRELOAD;
                end else if (fcnt_q <= FW'(1)) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scoreboard shift; a stalled or flushed decode slot enters as a bubble
    always_comb begin
        sb_vld_d    = '0;
        sb_rd_d     = '0;
        sb_vld_d[0] = wr & ~stall & ~flush;
        sb_rd_d[0]  = rd;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            sb_vld_d[k] = sb_vld_q[k-1];
            sb_rd_d[k]  = sb_rd_q[k-1];
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (bus.branch_taken_i && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            sb_vld_q    <= '0;
            sb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            sb_vld_q    <= sb_vld_d;
            sb_rd_q     <= sb_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RAW stalls, x0/store exclusions,
// flush sequencing and priority, and asynchronous reset mid-stall.
module tb_hazard_ctrl;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam logic [31:0] ADDI_X5    = 32'h00100293;
    localparam logic [31:0] ADD_X6_X5  = 32'h00528333;
    localparam logic [31:0] ADDI_X0    = 32'h00100013;
    localparam logic [31:0] ADD_X6_X0  = 32'h00000333;
    localparam logic [31:0] SW_X5      = 32'h0052a023;
    localparam logic [31:0] ADD_X7     = 32'h006283b3;
    localparam logic [31:0] ADDI_X7    = 32'h00100393;
    localparam logic [31:0] SW_X7      = 32'h00712023;
    localparam logic [31:0] ADD_X9_X5  = 32'h005284b3;
    localparam logic [31:0] ADD_X10_X9 = 32'h00948533;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    hazard_ctrl_if #(.CNT_W(32)) bus ();

    hazard_ctrl #(.PIPE_DEPTH(3), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] ins, input logic br);
        bus.instr_i        = ins;
        bus.hazard_rs1_i   = 1'b1;
        bus.hazard_rs2_i   = 1'b1;
        bus.branch_taken_i = br;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(NOP, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, with a branch request held to prove outputs are gated
        apply(ADD_X6_X5, 1'b1);
        tick();
        #1;
        chk("rst_flush", {31'd0, bus.flush_o}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_en_o}, 32'd0);
        chk("rst_scnt", bus.stall_cnt_o, 32'd0);
        chk("rst_fcnt", bus.flush_cnt_o, 32'd0);
        do_reset();

        // 1: addi x5 then add x6,x5,x5 -> exactly 3 stall cycles
        apply(ADDI_X5, 1'b0);
        chk("t1_c0_stall", {31'd0, bus.stall_en_o}, 32'd0);
        tick(); apply(ADD_X6_X5, 1'b0);
        chk("t1_c1_stall", {31'd0, bus.stall_en_o}, 32'd1);
        tick(); #1;
        chk("t1_c2_stall", {31'd0, bus.stall_en_o}, 32'd1);
        tick(); #1;
        chk("t1_c3_stall", {31'd0, bus.stall_en_o}, 32'd1);
        tick(); #1;
        chk("t1_c4_stall", {31'd0, bus.stall_en_o}, 32'd0);
        chk("t1_scnt", bus.stall_cnt_o, 32'd3);

        // 2: x0 destination untracked, x0 sources ignored
        do_reset();
        apply(ADDI_X0, 1'b0);
        chk("t2_c0_stall", {31'd0, bus.stall_en_o}, 32'd0);
        tick(); apply(ADD_X6_X0, 1'b0);
        chk("t2_c1_stall", {31'd0, bus.stall_en_o}, 32'd0);
        tick(); #1;
        chk("t2_scnt", bus.stall_cnt_o, 32'd0);

        // 3a: store is not a producer
        do_reset();
        apply(SW_X5, 1'b0);
        tick(); apply(ADD_X7, 1'b0);
        chk("t3_st_nostall", {31'd0, bus.stall_en_o}, 32'd0);
        // 3b: addi x7 then sw x7 -> 3-cycle stall through rs2
        do_reset();
        apply(ADDI_X7, 1'b0);
        tick(); apply(SW_X7, 1'b0);
        chk("t3_rs2_c1", {31'd0, bus.stall_en_o}, 32'd1);
        tick(); #1;
        chk("t3_rs2_c2", {31'd0, bus.stall_en_o}, 32'd1);
        tick(); #1;
        chk("t3_rs2_c3", {31'd0, bus.stall_en_o}, 32'd1);
        tick(); #1;
        chk("t3_rs2_c4", {31'd0, bus.stall_en_o}, 32'd0);
        chk("t3_scnt", bus.stall_cnt_o, 32'd3);

        // 4: one-cycle redirect while decode has a RAW hazard
        do_reset();
        apply(ADDI_X5, 1'b0);
        tick(); apply(ADD_X9_X5, 1'b1);
        chk("t4_c1_flush", {31'd0, bus.flush_o}, 32'd1);
        chk("t4_c1_stall", {31'd0, bus.stall_en_o}, 32'd0);
        tick(); apply(ADD_X9_X5, 1'b0);
        chk("t4_c2_flush", {31'd0, bus.flush_o}, 32'd1);
        chk("t4_c2_stall", {31'd0, bus.stall_en_o}, 32'd0);
        // flushed add x9 must not be tracked: a reader of x9 sees no hazard
        tick(); apply(ADD_X10_X9, 1'b0);
        chk("t4_c3_flush", {31'd0, bus.flush_o}, 32'd0);
        chk("t4_c3_stall", {31'd0, bus.stall_en_o}, 32'd0);
        chk("t4_fcnt", bus.flush_cnt_o, 32'd1);
        chk("t4_scnt", bus.stall_cnt_o, 32'd0);

        // 5: back-to-back redirects keep flush continuous for 3 cycles
        do_reset();
        apply(NOP, 1'b1);
        chk("t5_c0_flush", {31'd0, bus.flush_o}, 32'd1);
        tick(); apply(NOP, 1'b1);
        chk("t5_c1_flush", {31'd0, bus.flush_o}, 32'd1);
        tick(); apply(NOP, 1'b0);
        chk("t5_c2_flush", {31'd0, bus.flush_o}, 32'd1);
        tick(); #1;
        chk("t5_c3_flush", {31'd0, bus.flush_o}, 32'd0);
        chk("t5_fcnt", bus.flush_cnt_o, 32'd2);

        // 6: async reset mid-stall clears everything before the next edge
        do_reset();
        apply(ADDI_X5, 1'b0);
        tick(); apply(ADD_X6_X5, 1'b0);
        tick(); #1;
        chk("t6_pre_stall", {31'd0, bus.stall_en_o}, 32'd1);
        chk("t6_pre_scnt", bus.stall_cnt_o, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_stall", {31'd0, bus.stall_en_o}, 32'd0);
        chk("t6_rst_scnt", bus.stall_cnt_o, 32'd0);
        chk("t6_rst_fcnt", bus.flush_cnt_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_rel_stall", {31'd0, bus.stall_en_o}, 32'd0);
        tick(); #1;
        chk("t6_post_stall", {31'd0, bus.stall_en_o}, 32'd0);
        chk("t6_post_flush", {31'd0, bus.flush_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Hard bound on simulated time
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
